// File: rtl/pipeline_ifp_stage2_pkg.sv
// Shared types and constants for the second fetch stage (instruction return path).
// DRAM_BASE_ADDR normally comes from the global defines file; the guard keeps that copy authoritative.
`ifndef DRAM_BASE_ADDR
`define DRAM_BASE_ADDR 64'h0000_0000_8000_0000
`endif

package pipeline_ifp_stage2_pkg;

   localparam int XLEN                 = 64;
   localparam int ILEN                 = 32;
   localparam int DRAM_TIMEOUT_DEFAULT = 255;

   localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN,
      DRAM_WAIT,
      FLUSH_DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
      logic            valid;
      logic            misalign;
   } fetch_out_t;

   function automatic fetch_out_t make_out(input logic [XLEN-1:0] pc,
                                           input logic [ILEN-1:0] inst,
                                           input logic            misalign);
      fetch_out_t o;
      o.pc       = pc;
      o.inst     = inst;
      o.valid    = 1'b1;
      o.misalign = misalign;
      return o;
   endfunction

endpackage

// File: rtl/pipeline_ifp_stage2_if.sv
// Fetch-side bus: PC and read data in from the address stage/memories, IF/ID triple out.
interface pipeline_ifp_stage2_if;
   import pipeline_ifp_stage2_pkg::*;

   logic [XLEN-1:0] pc_IFP;
   logic [ILEN-1:0] rom_data;
   logic [63:0]     dram_data;
   logic            dram_rvalid;

   logic [XLEN-1:0] pc_IF;
   logic [ILEN-1:0] inst_IF;
   logic            valid_IF;
   logic            fetch_misalign;

   modport master (
      output pc_IFP, rom_data, dram_data, dram_rvalid,
      input  pc_IF, inst_IF, valid_IF, fetch_misalign
   );

   modport slave (
      input  pc_IFP, rom_data, dram_data, dram_rvalid,
      output pc_IF, inst_IF, valid_IF, fetch_misalign
   );
endinterface

// File: rtl/pipeline_ifp_stage2_word_sel.sv
// Picks the 32-bit word out of a 64-bit DRAM beat and flags non-word-aligned addresses.
module fetch_word_sel
   import pipeline_ifp_stage2_pkg::*;
(
   input  logic [2:0]      addr_lo,
   input  logic [63:0]     beat,
   output logic [ILEN-1:0] word,
   output logic            misalign
);

   assign word     = addr_lo[2] ? beat[63:32] : beat[31:0];
   assign misalign = (addr_lo[1:0] != 2'b00);

endmodule

// File: rtl/pipeline_ifp_stage2.sv
// Fetch stage 2: returns the instruction for pc_IFP from ROM or DRAM, tracks
// outstanding DRAM beats across stalls and flushes, and drives the IF/ID outputs.
module pipeline_ifp_stage2
   import pipeline_ifp_stage2_pkg::*;
#(
   parameter int DRAM_TIMEOUT = DRAM_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  branch_taken,
   pipeline_ifp_stage2_if.slave  fif,
   output logic                  fetch_busy,
   output logic                  fetch_fault
);

   localparam int CNT_W = $clog2(DRAM_TIMEOUT + 1);

   fetch_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   fetch_out_t      out_q, out_d;
   logic [ILEN-1:0] hold_q, hold_d;
   logic            hold_v_q, hold_v_d;
   logic            fault_d;

   logic [ILEN-1:0] dram_word;
   logic            misalign;
   logic            is_dram;
   logic            cap_en;
   logic            timeout;
   logic            owed;

   fetch_word_sel u_word_sel (
      .addr_lo  (fif.pc_IFP[2:0]),
      .beat     (fif.dram_data),
      .word     (dram_word),
      .misalign (misalign)
   );

   assign is_dram = (fif.pc_IFP >= `DRAM_BASE_ADDR);
   assign cap_en  = !stall && !branch_taken;
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign timeout = (cnt_inc == CNT_W'(DRAM_TIMEOUT));

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      out_d      = out_q;
      hold_d     = hold_q;
      hold_v_d   = hold_v_q;
      fault_d    = fetch_fault;
      fetch_busy = 1'b0;
      owed       = 1'b0;

      unique case (state_q)
         RUN: begin
            if (misalign) begin
               if (cap_en) out_d = make_out(fif.pc_IFP, NOP_INST, 1'b1);
            end else if (!is_dram) begin
               if (cap_en) out_d = make_out(fif.pc_IFP, fif.rom_data, 1'b0);
            end else if (fif.dram_rvalid) begin
               if (cap_en) out_d = make_out(fif.pc_IFP, dram_word, 1'b0);
            end else begin
               fetch_busy = 1'b1;
               owed       = 1'b1;
               state_d    = DRAM_WAIT;
               cnt_d      = CNT_W'(1);
            end
         end

         DRAM_WAIT: begin
            if (hold_v_q) begin
               if (cap_en) begin
                  out_d    = make_out(fif.pc_IFP, hold_q, 1'b0);
                  hold_v_d = 1'b0;
                  state_d  = RUN;
               end
            end else if (fif.dram_rvalid) begin
               if (cap_en) begin
                  out_d   = make_out(fif.pc_IFP, dram_word, 1'b0);
                  state_d = RUN;
               end else begin
                  hold_d   = dram_word;
                  hold_v_d = 1'b1;
               end
            end else begin
               fetch_busy = 1'b1;
               owed       = 1'b1;
               if (timeout) begin
                  fault_d     = 1'b1;
                  out_d.valid = 1'b0;
                  state_d     = RUN;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         FLUSH_DRAIN: begin
            if (fif.dram_rvalid) begin
               // Stale beat is dropped; the PC now presented is handled as in RUN.
               if (is_dram && !misalign) begin
                  fetch_busy = 1'b1;
                  owed       = 1'b1;
                  state_d    = DRAM_WAIT;
                  cnt_d      = CNT_W'(1);
               end else begin
                  state_d = RUN;
                  if (cap_en)
                     out_d = make_out(fif.pc_IFP, misalign ? NOP_INST : fif.rom_data, misalign);
               end
            end else begin
               fetch_busy = 1'b1;
               owed       = 1'b1;
               if (timeout) begin
                  fault_d = 1'b1;
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         default: state_d = RUN;
      endcase

      // Flush wins over stall, capture and timeout; only an unreturned beat forces a drain.
      if (branch_taken) begin
         out_d.valid    = 1'b0;
         out_d.inst     = NOP_INST;
         out_d.misalign = 1'b0;
         out_d.pc       = out_q.pc;
         hold_v_d       = 1'b0;
         fault_d        = fetch_fault;
         state_d        = owed ? FLUSH_DRAIN : RUN;
         cnt_d          = owed ? CNT_W'(1) : '0;
      end

      if (reset) fetch_busy = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         out_q       <= '{pc: '0, inst: NOP_INST, valid: 1'b0, misalign: 1'b0};
         // NOTE: the hold word is reset too; it is a single register, and a known value keeps reset state deterministic.
         hold_q      <= '0;
         hold_v_q    <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge next-state values.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         hold_q      <= hold_d;
         hold_v_q    <= hold_v_d;
         fetch_fault <= fault_d;
      end
   end

   assign fif.pc_IF          = out_q.pc;
   assign fif.inst_IF        = out_q.inst;
   assign fif.valid_IF       = out_q.valid;
   assign fif.fetch_misalign = out_q.misalign;

endmodule

// File: doc/pipeline_ifp_stage2.md
Name: pipeline_ifp_stage2

Overview:
- Second half of the split fetch stage, directly downstream of the PC/address-issue stage.
- Consumes pc_IFP (registered PC) and returns the 32-bit instruction for it, from boot ROM (fixed 1-cycle path) or DRAM (variable latency, 64-bit beat).
- Produces the IF/ID-facing triple pc_IF / inst_IF / valid_IF.
- Raises fetch_busy to the hazard unit while DRAM data is outstanding. Absorbs branch flushes, including discarding stale DRAM responses.

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).
- DRAM_TIMEOUT, 255, cycles in DRAM_WAIT before fetch_fault; counter width $clog2(DRAM_TIMEOUT+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  global pipeline stall from hazard unit; may already include fetch_busy
- branch_taken  in  1  flush request, same signal the upstream stage uses
- pc_IFP  in  64  PC whose instruction is being fetched this cycle
- rom_data  in  32  ROM read data for pc_IFP, valid in the cycle pc_IFP is presented
- dram_data  in  64  DRAM read beat
- dram_rvalid  in  1  dram_data valid this cycle
- fetch_busy  out  1  combinational; request stall while DRAM fetch pending or draining
- fetch_fault  out  1  registered sticky flag, DRAM timeout; cleared only by reset
- fetch_misalign  out  1  registered; accompanies valid_IF when pc_IF[1:0]!=0
- pc_IF  out  64  PC of delivered instruction
- inst_IF  out  32  delivered instruction
- valid_IF  out  1  pc_IF/inst_IF hold a real instruction

Behaviour:
- Reset (async, immediate):
  - state=RUN, pc_IF=0, inst_IF=NOP_INST, valid_IF=0.
  - fetch_misalign=0, fetch_fault=0, timeout counter=0.
  - fetch_busy is combinationally 0.
- Channel: is_dram = (pc_IFP >= `DRAM_BASE_ADDR`), using the shared define.
- DRAM word select: pc_IFP[2]=0 selects dram_data[31:0]; pc_IFP[2]=1 selects dram_data[63:32].
- Capture rule: output registers load only on a clock edge with stall=0 and branch_taken=0. Otherwise outputs hold, except on flush (below).
- State RUN:
  - ROM channel: fetch_busy=0. On a capture edge: pc_IF<=pc_IFP, inst_IF<=rom_data, valid_IF<=1. Latency 1 cycle.
  - DRAM channel with dram_rvalid=1: same as ROM but loads the selected DRAM word. fetch_busy=0.
  - DRAM channel with dram_rvalid=0: fetch_busy=1. On the next edge go to DRAM_WAIT and load counter=1. Outputs hold, unless flushed.
- State DRAM_WAIT:
  - fetch_busy=1 until dram_rvalid.
  - On dram_rvalid: fetch_busy drops combinationally and the word is captured that edge, subject to stall=0. If stall=1 coincides with dram_rvalid, the word is latched into an internal 32-bit hold register plus hold-valid bit, fetch_busy stays 0, and the word is delivered on the first stall=0 edge. Then return to RUN.
  - Counter increments each cycle. Reaching DRAM_TIMEOUT sets fetch_fault=1 and returns to RUN with valid_IF=0.
- State FLUSH_DRAIN:
  - fetch_busy=1 and valid_IF=0.
  - The first dram_rvalid is discarded (stale beat); go to RUN.
  - Timeout applies here as in DRAM_WAIT.
- Flush (branch_taken=1 on an edge):
  - valid_IF<=0, inst_IF<=NOP_INST, fetch_misalign<=0. pc_IF holds.
  - Hold register is cleared.
  - If a DRAM beat is outstanding (state DRAM_WAIT, or RUN/DRAM with rvalid=0), go to FLUSH_DRAIN; otherwise go to RUN.
  - Flush takes priority over stall and capture.
  - branch_taken while already in FLUSH_DRAIN: remain there; still only one beat is owed.
- Misalignment: pc_IFP[1:0]!=0 is checked on capture. Deliver inst_IF=NOP_INST, valid_IF=1, fetch_misalign=1 for that instruction. No DRAM wait is performed; fetch_busy=0 for it.
- Stall with valid_IF=1: pc_IF, inst_IF and valid_IF are bit-stable for the whole stall.
- dram_rvalid while in RUN with a ROM pc_IFP: ignored.

Decomposition:
- Shared package gets:
  - fetch_state_e {RUN, DRAM_WAIT, FLUSH_DRAIN}
  - NOP_INST constant
  - fetch_out_t struct {pc, inst, valid, misalign}
- DRAM_BASE_ADDR stays in the existing defines file.
- One natural sub-module: fetch_word_sel (combinational 64→32 word select plus misalign check), reusable by the load path.

Test Plan:
- ROM stream:
  - Stimulus: reset, pc_IFP=0,4,8 with rom_data=0x00100093,0x00200113,0x00300193, no stall.
  - Required: one cycle later each, valid_IF=1 with matching pc_IF/inst_IF; fetch_busy=0 throughout.
- DRAM latency-3:
  - Stimulus: pc_IFP=0x8000_0004; dram_rvalid asserted on the 3rd cycle with dram_data=0xAAAA_BBBB_1111_2222.
  - Required: fetch_busy=1 for 2 cycles then 0; inst_IF=0xAAAABBBB, pc_IF=0x80000004, valid_IF=1.
- Flush during DRAM_WAIT:
  - Stimulus: pending fetch at 0x8000_0000, branch_taken pulse, then stale rvalid 2 cycles later, then ROM pc 0x100.
  - Required: valid_IF=0 and inst_IF=0x13 after the flush; stale beat never appears; fetch_busy clears on the stale rvalid; 0x100 delivered next.
- Stall hold / coincident rvalid:
  - Stimulus: stall=1 for 4 cycles with dram_rvalid in cycle 2.
  - Required: outputs bit-stable during the stall, fetch_busy=0 after rvalid, the DRAM word delivered on the first unstalled edge.
- Misaligned pc:
  - Stimulus: pc_IFP=0x102.
  - Required: valid_IF=1, inst_IF=0x13, fetch_misalign=1 for exactly that instruction.
- Timeout and mid-operation reset:
  - Stimulus: DRAM pc with no rvalid for DRAM_TIMEOUT cycles, then reset asserted mid-wait.
  - Required: fetch_fault=1 at the timeout; reset immediately forces state RUN, valid_IF=0, fetch_fault=0 with no clock edge.
